// File: rtl/edge_implication_monitor.sv
`default_nettype none
// ============================================================================
// Module   : edge_implication_monitor
// Purpose  : Multi-channel hardware checker for "a implies an edge/stability
//            condition on b within a window", with pulses, stickies, counters.
// Revision : 1.0 - initial release
// ============================================================================
module edge_implication_monitor #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [1:0]           mode,
    input  logic [WIN_W-1:0]     window,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       pass_pulse,
    output logic [NCH-1:0]       fail_pulse,
    output logic [NCH-1:0]       fail_sticky,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    localparam logic [1:0] c_mode_rose    = 2'b00;
    localparam logic [1:0] c_mode_fell    = 2'b01;
    localparam logic [1:0] c_mode_changed = 2'b10;

    localparam logic [WIN_W-1:0] c_rem_last = WIN_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    function automatic logic f_cond(input logic [1:0] m, input logic prev, input logic cur);
        logic res;
        case (m)
            c_mode_rose:    res = ~prev & cur;
            c_mode_fell:    res = prev & ~cur;
            c_mode_changed: res = prev ^ cur;
            default:        res = ~(prev ^ cur);
        endcase
        return res;
    endfunction

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic [0:0]       r_state;
            logic [1:0]       r_mode;
            logic [WIN_W-1:0] r_rem;
            logic             r_b_prev;
            logic             r_pass;
            logic             r_fail;
            logic             r_sticky;
            logic [CNT_W-1:0] r_pass_cnt;
            logic [CNT_W-1:0] r_fail_cnt;

            logic [1:0]       w_mode_eff;
            logic             w_cond;
            logic             w_pass;
            logic             w_fail;

            // A launching attempt judges with the live mode; a pending one
            // keeps the mode it was launched with.
            always_comb begin
                w_mode_eff = (r_state == c_st_wait) ? r_mode : mode;
                w_cond     = f_cond(w_mode_eff, r_b_prev, b[i]);
                w_pass     = 1'b0;
                w_fail     = 1'b0;
                case (r_state)
                    c_st_idle: begin
                        if (en && a[i]) begin
                            if (w_cond)
                                w_pass = 1'b1;
                            else if (window == '0)
                                w_fail = 1'b1;
                        end
                    end
                    default: begin
                        if (en) begin
                            if (w_cond)
                                w_pass = 1'b1;
                            else if (r_rem == c_rem_last)
                                w_fail = 1'b1;
                        end
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state  <= c_st_idle;
                    r_mode   <= 2'b00;
                    r_rem    <= '0;
                    r_b_prev <= 1'b0;
                    r_pass   <= 1'b0;
                    r_fail   <= 1'b0;
                end else begin
                    r_b_prev <= b[i];
                    r_pass   <= w_pass;
                    r_fail   <= w_fail;
                    case (r_state)
                        c_st_idle: begin
                            if (en && a[i]) begin
                                r_mode <= mode;
                                if (!w_cond && (window != '0)) begin
                                    r_state <= c_st_wait;
                                    r_rem   <= window;
                                end
                            end
                        end
                        default: begin
                            if (!en || w_pass || w_fail)
                                r_state <= c_st_idle;
                            else
                                r_rem <= r_rem - c_rem_last;
                        end
                    endcase
                end
            end

            // clr outranks a coincident increment; a coincident fail outranks clr.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pass_cnt <= '0;
                    r_fail_cnt <= '0;
                    r_sticky   <= 1'b0;
                end else begin
                    if (clr)
                        r_pass_cnt <= '0;
                    else if (w_pass && (r_pass_cnt != c_cnt_max))
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);

                    if (clr)
                        r_fail_cnt <= '0;
                    else if (w_fail && (r_fail_cnt != c_cnt_max))
                        r_fail_cnt <= r_fail_cnt + CNT_W'(1);

                    if (w_fail)
                        r_sticky <= 1'b1;
                    else if (clr)
                        r_sticky <= 1'b0;
                end
            end

            assign busy[i]                        = (r_state == c_st_wait);
            assign pass_pulse[i]                  = r_pass;
            assign fail_pulse[i]                  = r_fail;
            assign fail_sticky[i]                 = r_sticky;
            assign pass_cnt[i*CNT_W +: CNT_W]     = r_pass_cnt;
            assign fail_cnt[i*CNT_W +: CNT_W]     = r_fail_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_edge_implication_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_implication_monitor
// Purpose  : Directed scoreboard bench for edge_implication_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_implication_monitor;

    localparam int NCH   = 4;
    localparam int CNT_W = 4;
    localparam int WIN_W = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b1;
    logic                 clr = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic [WIN_W-1:0]     window = '0;
    logic [NCH-1:0]       a = '0;
    logic [NCH-1:0]       b = '0;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       pass_pulse;
    logic [NCH-1:0]       fail_pulse;
    logic [NCH-1:0]       fail_sticky;
    logic [NCH*CNT_W-1:0] pass_cnt;
    logic [NCH*CNT_W-1:0] fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [NCH-1:0] p;
        logic [NCH-1:0] f;
        logic [NCH-1:0] bz;
    } exp_t;

    exp_t exp_q[$];

    edge_implication_monitor #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .window(window),
        .a(a), .b(b), .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .fail_sticky(fail_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [CNT_W-1:0] pc(input int ch);
        return pass_cnt[ch*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] fc(input int ch);
        return fail_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Drive one cycle of (a,b) and queue the pulses/busy expected after the edge.
    task automatic step(input logic [NCH-1:0] av, input logic [NCH-1:0] bv,
                        input logic [NCH-1:0] ep, input logic [NCH-1:0] ef,
                        input logic [NCH-1:0] eb);
        exp_t e;
        a = av;
        b = bv;
        e.p  = ep;
        e.f  = ef;
        e.bz = eb;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge with an outstanding expectation is checked.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cycle_pass_fail_busy", {52'd0, pass_pulse, fail_pulse, busy}, {52'd0, e.p, e.f, e.bz});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [NCH-1:0] ep;
        logic [NCH-1:0] ef;
        logic [NCH-1:0] chm;

        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy",   64'(busy), 64'd0);
        chk("reset_pass",   64'(pass_pulse), 64'd0);
        chk("reset_fail",   64'(fail_pulse), 64'd0);
        chk("reset_sticky", 64'(fail_sticky), 64'd0);
        chk("reset_pcnt",   64'(pass_cnt), 64'd0);
        chk("reset_fcnt",   64'(fail_cnt), 64'd0);
        rst = 1'b0;

        // Same-cycle rose on channel 0
        mode = 2'b00; window = '0;
        step(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++)
            step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        chk("t1_pass_cnt0", 64'(pc(0)), 64'd2);
        chk("t1_fail_cnt0", 64'(fc(0)), 64'd6);
        chk("t1_sticky",    64'(fail_sticky), 64'b0001);

        // Windowed rose: pass at third edge, then timeout
        window = 4'd3;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        chk("t2_pass_cnt0", 64'(pc(0)), 64'd3);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        chk("t2_fail_cnt0", 64'(fc(0)), 64'd7);

        // Clear, then saturate fail counter, then clr racing a fail
        window = '0; clr = 1'b1;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        clr = 1'b0;
        chk("t3_clr_pcnt",   64'(pass_cnt), 64'd0);
        chk("t3_clr_fcnt",   64'(fail_cnt), 64'd0);
        chk("t3_clr_sticky", 64'(fail_sticky), 64'd0);
        for (int k = 0; k < 20; k++)
            step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        chk("t3_sat_fcnt0", 64'(fc(0)), 64'd15);
        clr = 1'b1;
        step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        clr = 1'b0;
        chk("t3_clr_vs_fail_fcnt0",   64'(fc(0)), 64'd0);
        chk("t3_clr_vs_fail_sticky", 64'(fail_sticky), 64'b0001);

        // Fell / changed / stable on channels 1..3, b falling then held low
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            chm  = 4'(1 << m);
            step(4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
            ep = (m == 3) ? 4'b0000 : chm;
            ef = (m == 3) ? chm : 4'b0000;
            step(chm, 4'b0000, ep, ef, 4'b0000);
            step(chm, 4'b0000, ef, ep, 4'b0000);
        end
        chk("t4_pcnt123", 64'({pc(3), pc(2), pc(1)}), 64'h111);
        chk("t4_fcnt123", 64'({fc(3), fc(2), fc(1)}), 64'h111);
        chk("t4_sticky",  64'(fail_sticky), 64'b1111);

        // Mode latched at launch: rose attempt still passes after mode -> fell
        mode = 2'b00; window = 4'd2;
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        mode = 2'b01;
        step(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        chk("t4b_latched_pcnt1", 64'(pc(1)), 64'd2);

        // Abort by dropping en mid-window
        mode = 2'b00; window = 4'd5;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        en = 1'b0;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        en = 1'b1;
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk("t5_abort_pcnt0", 64'(pc(0)), 64'd0);
        chk("t5_abort_fcnt0", 64'(fc(0)), 64'd0);

        // Reset mid-WAIT with b_prev high, then first b=1 counts as a rise
        step(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        step(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        rst = 1'b1;
        a = 4'b0001;
        #1;
        chk("t6_rst_busy",   64'(busy), 64'd0);
        chk("t6_rst_pulses", 64'({pass_pulse, fail_pulse}), 64'd0);
        chk("t6_rst_sticky", 64'(fail_sticky), 64'd0);
        chk("t6_rst_cnts",   64'({pass_cnt, fail_cnt}), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        window = '0;
        step(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        chk("t6_post_rst_pcnt0", 64'(pc(0)), 64'd1);
        chk("t6_post_rst_fcnt0", 64'(fc(0)), 64'd0);

        a = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_implication_monitor.md
# edge_implication_monitor

Synthesizable multi-channel implication checker: per channel, when antecedent `a[i]` is sampled high, consequent `b[i]` must show a selected edge or stability condition on the same clock or within a programmable window. It generalises the `a |-> $rose(b)` simulation assertion into hardware usable in FPGA builds and emulation:

- runtime-selectable check mode;
- bounded delay window;
- per-channel pass/fail pulses, sticky fail flags and saturating counters.

It sits beside the design under test, sampling on the design clock.

## Interface
- `NCH`, 4, number of independent channels
- `CNT_W`, 16, width of each pass/fail counter
- `WIN_W`, 4, width of the window value

- `clk`  in  1  sampling clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  global enable; low = no new attempts, in-flight attempts aborted
- `clr`  in  1  synchronous clear of counters and sticky flags
- `mode`  in  2  00 rose (`!b_prev & b`), 01 fell (`b_prev & !b`), 10 changed (`b_prev ^ b`), 11 stable (`b_prev ~^ b`)
- `window`  in  WIN_W  extra cycles allowed after the launch cycle; 0 = same-cycle check
- `a`  in  NCH  antecedent per channel
- `b`  in  NCH  consequent per channel
- `busy`  out  NCH  channel has an attempt pending (WAIT state)
- `pass_pulse`  out  NCH  one-cycle pass indication
- `fail_pulse`  out  NCH  one-cycle fail indication
- `fail_sticky`  out  NCH  set on any fail, held until `clr`
- `pass_cnt`  out  NCH*CNT_W  channel i at bits [i*CNT_W +: CNT_W]
- `fail_cnt`  out  NCH*CNT_W  same packing

## Operation
- **Reset values.** `rst` high resets all outputs to 0, every `b_prev` to 0 and every FSM to IDLE.
- **`b_prev`.** Per channel, `b_prev` registers `b` on every edge, regardless of `en`. Edge condition `cond[i]` is computed from `b_prev[i]`, `b[i]` and the channel's active mode.
- **IDLE state.**
  - If `en & a[i]`, an attempt launches and `mode` is latched as the channel mode.
  - If `cond` is true under the sampled `mode` → pass.
  - Else if `window==0` → fail.
  - Else → WAIT, with `rem <= window`.
  - `a[i]` low → vacuous: no pulse, no count.
- **WAIT state.**
  - `en` low → IDLE, no pulse, no count.
  - Else if `cond` under the latched mode → pass, IDLE.
  - Else if `rem==1` → fail, IDLE.
  - Else `rem <= rem-1`.
  - `a[i]` is ignored while in WAIT; there are no overlapping attempts per channel.
- **Pass / fail effects.**
  - Pass: `pass_pulse[i]` high for one cycle; `pass_cnt[i]` increments.
  - Fail: `fail_pulse[i]` high for one cycle; `fail_cnt[i]` increments; `fail_sticky[i]` set.
- **Counters.** Saturate at 2^CNT_W−1 and never wrap.
- **`clr`.**
  - Counters go to 0. `clr` beats a coincident increment, so the result is 0.
  - `fail_sticky` goes to 0, unless a fail coincides on that channel, in which case the sticky ends set (fail wins).
  - `clr` does not affect FSMs, pulses or `b_prev`.
- **Mode/window changes.** Changes during WAIT affect only later attempts.

## Timing
- **Launch edge.** The rising edge where `a[i]` is sampled high in IDLE; call it edge k.
- **Result latency.** The deciding edge d lies in k..k+window. `pass_pulse`/`fail_pulse` and the counter update are registered and visible from edge d until edge d+1.
- **Back-to-back attempts.**
  - A channel returns to IDLE at the deciding edge, so a new attempt can launch at edge d+1.
  - With `window==0` an attempt can resolve on every edge, giving continuous pulses.
- **Timeout edge.** Without `cond`, fail occurs at edge k+window.
- **`busy[i]`.** High from edge k until the deciding edge; it is 0 when `window==0`.
- **Reset.**
  - `rst` clears state immediately, including mid-WAIT.
  - After release, the first sampled `b=1` counts as a rise, because `b_prev=0`.
- **Channel independence.** Channels are fully independent; simultaneous events on different channels are all counted.

## Test plan
- **Same-cycle rose check.** `mode`=00, `window`=0, channel 0. Per-cycle (a,b) = (0,1),(1,0),(1,1),(0,0),(1,1), then (1,1) held for 5 cycles → fail, pass, pass, then 5 fails. Final `pass_cnt[0]`=2, `fail_cnt[0]`=6, `fail_sticky[0]`=1.
- **Windowed rose check.** `window`=3, `mode`=00.
  - `a` pulse at edge 0 with b=0, b rises at edge 2 → `busy` high over edges 0–2, `pass_pulse` after edge 2.
  - Repeat with b held 0 → `fail_pulse` after edge 3.
- **Counter saturation.** `CNT_W`=4, 20 consecutive fails → `fail_cnt`=15. Then `clr` coincident with a fail → `fail_cnt`=0, `fail_sticky`=1.
- **Modes on parallel channels.** `mode`=01/10/11 on channels 1–3, `window`=0, b toggling 1→0 with `a` high:
  - fell passes; changed passes; stable fails.
  - Next cycle with b held: fell fails; changed fails; stable passes.
- **Abort on `en` low.** Attempt launched with `window`=5, `en` dropped at edge 2 → `busy` low after edge 2, no pulse, counters unchanged.
- **Reset mid-WAIT.** `rst` asserted mid-WAIT → `busy`, pulses and counts are 0 immediately. After release, `a`=1, b=1 at the first edge → pass (`pass_cnt`=1).
